// File: rtl/wb_host_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_host_master_if                                            |
// | Description : Request/response handshake and Wishbone master bus bundle.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wb_host_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_W-1:0]     req_adr_i;
    logic [DATA_W-1:0]     req_dat_i;
    logic [DATA_W/8-1:0]   req_sel_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_dat_o;
    logic                  rsp_err_o;
    logic                  wbm_cyc_o;
    logic                  wbm_stb_o;
    logic                  wbm_we_o;
    logic [ADDR_W-1:0]     wbm_adr_o;
    logic [DATA_W-1:0]     wbm_dat_o;
    logic [DATA_W/8-1:0]   wbm_sel_o;
    logic                  wbm_ack_i;
    logic [DATA_W-1:0]     wbm_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_host_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_host_master                                               |
// | Description : Single-transfer Wishbone classic initiator with timeout.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_host_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic         wb_clk_i,
    input  wire logic         wb_rst_ni,
    wb_host_master_if.master  bus
);
    localparam int c_SEL_W     = DATA_W / 8;
    localparam int c_CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int c_TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(c_TO_LAST_I);
    localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_live;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [c_SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic                r_rsp_err;

    logic w_ready;
    logic w_accept;
    logic w_ack;
    logic w_timeout;

    // r_live keeps req_ready low during reset and for the first edge after it
    always_comb begin
        w_ready   = (r_state == c_ST_IDLE) && r_live;
        w_accept  = w_ready && bus.req_valid_i;
        w_ack     = (r_state == c_ST_BUS) && bus.wbm_ack_i;
        w_timeout = c_TO_EN && (r_state == c_ST_BUS) && !bus.wbm_ack_i
                    && (r_cnt == c_TO_LAST);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)             w_next_state = c_ST_BUS;
            c_ST_BUS:  if (w_ack || w_timeout)   w_next_state = c_ST_RESP;
            c_ST_RESP: if (bus.rsp_ready_i)      w_next_state = c_ST_IDLE;
            default:                             w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = w_ready;
        bus.wbm_cyc_o   = (r_state == c_ST_BUS);
        bus.wbm_stb_o   = (r_state == c_ST_BUS);
        bus.rsp_valid_o = (r_state == c_ST_RESP);
        bus.wbm_we_o    = r_we;
        bus.wbm_adr_o   = r_adr;
        bus.wbm_dat_o   = r_dat;
        bus.wbm_sel_o   = r_sel;
        bus.rsp_dat_o   = r_rsp_dat;
        bus.rsp_err_o   = r_rsp_err;
    end

    // Request capture, ack-wait counter and response registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_live    <= 1'b0;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_we  <= bus.req_we_i;
                r_adr <= bus.req_adr_i;
                r_dat <= bus.req_dat_i;
                r_sel <= bus.req_sel_i;
                r_cnt <= '0;
            end else if ((r_state == c_ST_BUS) && !bus.wbm_ack_i) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            // Ack takes priority over a timeout landing on the same edge
            if (w_ack) begin
                r_rsp_dat <= r_we ? '0 : bus.wbm_dat_i;
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_dat <= '0;
                r_rsp_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_host_master                                            |
// | Description : Self-checking bench for wb_host_master (timeout of 8).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_host_master;
    localparam int TO = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] pend_adr;

    wb_host_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what a transaction should look like from the outside
    function automatic int exp_len(input int k);
        return (k == 0 || k > TO) ? TO : k;
    endfunction
    function automatic logic exp_err(input int k);
        return (k == 0 || k > TO);
    endfunction
    function automatic logic [31:0] exp_dat(input int k, input logic we, input logic [31:0] rdata);
        return (exp_err(k) || we) ? 32'h0 : rdata;
    endfunction
    function automatic logic [31:0] slave_mem(input logic [31:0] adr);
        return (adr ^ 32'h5A5A_A5A5) + 32'h0000_1111;
    endfunction

    // Drives one request, acks on bus cycle k (0 = never), holds rsp_ready low for hold cycles
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rdata, input int k,
                           input int hold, input bit pend,
                           output bit accept_ok, output int cyc_len, output bit bus_ok,
                           output logic rv, output logic [31:0] rd, output logic re,
                           output bit hold_ok);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_adr_i   = adr;
        bus.req_dat_i   = dat;
        bus.req_sel_i   = sel;
        accept_ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.req_ready_o) begin
                accept_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        cyc_len = 0;
        bus_ok  = 1'b1;
        while (bus.wbm_cyc_o && cyc_len < 40) begin
            cyc_len++;
            if (!bus.wbm_stb_o || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr
                || bus.wbm_dat_o !== dat || bus.wbm_sel_o !== sel)
                bus_ok = 1'b0;
            bus.wbm_ack_i = (cyc_len == k);
            bus.wbm_dat_i = (cyc_len == k) ? rdata : $urandom;
            @(negedge clk);
        end
        bus.wbm_ack_i = 1'b0;
        rv = bus.rsp_valid_o;
        rd = bus.rsp_dat_o;
        re = bus.rsp_err_o;
        hold_ok = 1'b1;
        if (pend) begin
            bus.req_valid_i = 1'b1;
            bus.req_we_i    = 1'b0;
            bus.req_adr_i   = pend_adr;
        end
        for (int n = 0; n < hold; n++) begin
            bus.wbm_ack_i = 1'($urandom_range(0, 1));
            bus.wbm_dat_i = $urandom;
            @(negedge clk);
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== rd || bus.rsp_err_o !== re
                || bus.req_ready_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0)
                hold_ok = 1'b0;
        end
        bus.wbm_ack_i   = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_adr_i = 0; bus.req_dat_i = 0;
        bus.req_sel_i = 0; bus.rsp_ready_i = 0; bus.wbm_ack_i = 0; bus.wbm_dat_i = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
             bus.rsp_valid_o, bus.rsp_err_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.req_ready_o, bus.wbm_cyc_o,
                     bus.wbm_stb_o, bus.wbm_we_o, bus.rsp_valid_o, bus.rsp_err_o});
        end
        checks++;
        if ({bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o, bus.rsp_dat_o} !== 100'b0) begin
            failures++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%h rsp_dat=%h expected all 0",
                     bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o, bus.rsp_dat_o);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_early: got %b expected 0", bus.req_ready_o);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after: got %b expected 1", bus.req_ready_o);
        end
    endtask

    task automatic test_write();
        bit acc, bok, hok; int len; logic rv, re; logic [31:0] rd;
        run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, $urandom, 3, 0, 1'b0,
                acc, len, bok, rv, rd, re, hok);
        checks++;
        if (!acc || len !== 3 || !bok) begin
            failures++;
            $display("FAIL write_bus: accept=%0d len=%0d stable=%0d expected 1/3/1", acc, len, bok);
        end
        checks++;
        if ({rv, re, rd} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL write_rsp: valid=%b err=%b dat=%h expected 1/0/00000000", rv, re, rd);
        end
        checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL write_done: rsp_valid=%b req_ready=%b expected 0/1",
                     bus.rsp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_read();
        bit acc, bok, hok; int len; logic rv, re; logic [31:0] rd;
        run_txn(1'b0, 32'h3000_0000, $urandom, 4'hF, 32'h1234_5678, 1, 0, 1'b0,
                acc, len, bok, rv, rd, re, hok);
        checks++;
        if (!acc || len !== 1 || !bok) begin
            failures++;
            $display("FAIL read_bus: accept=%0d len=%0d stable=%0d expected 1/1/1", acc, len, bok);
        end
        checks++;
        if ({rv, re, rd} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            failures++;
            $display("FAIL read_rsp: valid=%b err=%b dat=%h expected 1/0/12345678", rv, re, rd);
        end
    endtask

    task automatic test_timeout();
        bit acc, bok, hok; int len; logic rv, re; logic [31:0] rd;
        // k: never, exactly at the limit (ack wins), one past the limit
        int ks[3] = '{0, TO, TO + 1};
        foreach (ks[i]) begin
            run_txn(1'b0, $urandom, $urandom, 4'hF, 32'hFEED_0001, ks[i], 3, 1'b0,
                    acc, len, bok, rv, rd, re, hok);
            checks++;
            if (!acc || len !== exp_len(ks[i]) || !bok) begin
                failures++;
                $display("FAIL timeout_len k=%0d: accept=%0d len=%0d expected 1/%0d",
                         ks[i], acc, len, exp_len(ks[i]));
            end
            checks++;
            if ({rv, re, rd} !== {1'b1, exp_err(ks[i]), exp_dat(ks[i], 1'b0, 32'hFEED_0001)}
                || !hok) begin
                failures++;
                $display("FAIL timeout_rsp k=%0d: valid=%b err=%b dat=%h held=%0d expected 1/%b/%h/1",
                         ks[i], rv, re, rd, hok, exp_err(ks[i]),
                         exp_dat(ks[i], 1'b0, 32'hFEED_0001));
            end
        end
        bus.wbm_ack_i = 1'b1;
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack: cyc=%b rsp_valid=%b expected 0/0", bus.wbm_cyc_o, bus.rsp_valid_o);
        end
    endtask

    task automatic test_backpressure();
        bit acc, bok, hok; int len; logic rv, re; logic [31:0] rd;
        pend_adr = $urandom;
        run_txn(1'b0, 32'h3000_0008, $urandom, 4'h3, 32'hA1B2_C3D4, 2, 5, 1'b1,
                acc, len, bok, rv, rd, re, hok);
        checks++;
        if ({rv, re, rd} !== {1'b1, 1'b0, 32'hA1B2_C3D4} || !hok) begin
            failures++;
            $display("FAIL bp_hold: valid=%b err=%b dat=%h held=%0d expected 1/0/a1b2c3d4/1",
                     rv, re, rd, hok);
        end
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready: got %b expected 1", bus.req_ready_o);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        checks++;
        if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== pend_adr) begin
            failures++;
            $display("FAIL bp_next: cyc=%b adr=%h expected 1/%h", bus.wbm_cyc_o, bus.wbm_adr_o, pend_adr);
        end
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = slave_mem(pend_adr);
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== slave_mem(pend_adr)) begin
            failures++;
            $display("FAIL bp_next_rsp: valid=%b dat=%h expected 1/%h",
                     bus.rsp_valid_o, bus.rsp_dat_o, slave_mem(pend_adr));
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        bit acc, bok, hok; int len; logic rv, re; logic [31:0] rd; logic [31:0] rdata;
        bus.req_we_i    = 1'b0;
        bus.req_adr_i   = 32'h3000_0000;
        bus.req_valid_i = 1'b1;
        for (int n = 0; n < 20 && !bus.req_ready_o; n++) @(negedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        checks++;
        if (bus.wbm_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_started: cyc=%b expected 1", bus.wbm_cyc_o);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.req_ready_o} !== 4'b0) begin
            failures++;
            $display("FAIL rst_mid_async: cyc/stb/rsp_valid/ready=%b expected 0000",
                     {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.req_ready_o});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready_o, bus.wbm_cyc_o, bus.rsp_valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_release: ready/cyc/rsp_valid=%b expected 100",
                     {bus.req_ready_o, bus.wbm_cyc_o, bus.rsp_valid_o});
        end
        rdata = $urandom;
        run_txn(1'b0, 32'h3000_0000, $urandom, 4'hF, rdata, 2, 0, 1'b0,
                acc, len, bok, rv, rd, re, hok);
        checks++;
        if (!acc || len !== 2 || {rv, re, rd} !== {1'b1, 1'b0, rdata}) begin
            failures++;
            $display("FAIL rst_mid_fresh: len=%0d valid=%b err=%b dat=%h expected 2/1/0/%h",
                     len, rv, re, rd, rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] adr_a[4];
        logic [31:0] dat_a[4];
        logic        we_a[4];
        logic [31:0] e;
        int idx = 0, got = 0, last = -1;
        bit acc_prev = 1'b0, overlap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adr_a[i] = $urandom; dat_a[i] = $urandom; we_a[i] = 1'($urandom_range(0, 1));
        end
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_we_i = we_a[0]; bus.req_adr_i = adr_a[0]; bus.req_dat_i = dat_a[0];
        bus.req_sel_i = 4'hF;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (acc_prev) begin
                idx++;
                if (idx < 4) begin
                    bus.req_we_i = we_a[idx]; bus.req_adr_i = adr_a[idx]; bus.req_dat_i = dat_a[idx];
                end else begin
                    bus.req_valid_i = 1'b0;
                end
            end
            acc_prev = bus.req_valid_i && bus.req_ready_o;
            if (acc_prev) q.push_back(we_a[idx] ? 32'h0 : slave_mem(adr_a[idx]));
            if (bus.wbm_cyc_o && (bus.rsp_valid_o || bus.req_ready_o)) overlap = 1'b1;
            if (bus.rsp_valid_o) begin
                e = (q.size() != 0) ? q.pop_front() : 32'hXXXX_XXXX;
                checks++;
                if (bus.rsp_dat_o !== e || bus.rsp_err_o !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_rsp%0d: dat=%h err=%b expected %h/0", got, bus.rsp_dat_o,
                             bus.rsp_err_o, e);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 3) begin
                        failures++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles expected 3", got, c - last);
                    end
                end
                last = c;
                got++;
            end
            bus.wbm_ack_i = bus.wbm_cyc_o;
            bus.wbm_dat_i = slave_mem(bus.wbm_adr_o);
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0; bus.wbm_ack_i = 1'b0;
        checks++;
        if (got !== 4 || overlap) begin
            failures++;
            $display("FAIL b2b_count: responses=%0d overlap=%0d expected 4/0", got, overlap);
        end
    endtask

    task automatic test_random();
        bit acc, bok, hok; int len, k, hold; logic rv, re; logic [31:0] rd, adr, dat, rdata;
        logic we; logic [3:0] sel;
        for (int i = 0; i < 8; i++) begin
            we = 1'($urandom_range(0, 1)); adr = $urandom; dat = $urandom; rdata = $urandom;
            sel = 4'($urandom_range(0, 15)); k = $urandom_range(0, TO + 3);
            hold = $urandom_range(0, 3);
            run_txn(we, adr, dat, sel, rdata, k, hold, 1'b0, acc, len, bok, rv, rd, re, hok);
            checks++;
            if (!acc || len !== exp_len(k) || !bok || !hok) begin
                failures++;
                $display("FAIL rand%0d_bus k=%0d: accept=%0d len=%0d stable=%0d held=%0d expected 1/%0d/1/1",
                         i, k, acc, len, bok, hok, exp_len(k));
            end
            checks++;
            if ({rv, re, rd} !== {1'b1, exp_err(k), exp_dat(k, we, rdata)}) begin
                failures++;
                $display("FAIL rand%0d_rsp k=%0d: valid=%b err=%b dat=%h expected 1/%b/%h",
                         i, k, rv, re, rd, exp_err(k), exp_dat(k, we, rdata));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator: the master end of the bus the signal_generator slave sits on.
- Turns a simple valid/ready request port (from a test sequencer, SPI/UART bridge or LA-driven controller) into one Wishbone read or write cycle.
- Returns read data or a timeout error on a valid/ready response port.
- Used for bring-up and autonomous register sequencing of the user-project peripherals.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- TIMEOUT_CYCLES, 255, maximum bus cycles waiting for ack; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  sole clock; all logic is rising-edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted on this edge when high together with req_valid_i.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  ADDR_W  target address.
- req_dat_i  in  DATA_W  write data.
- req_sel_i  in  DATA_W/8  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  DATA_W  read data; 0 for writes and on error.
- rsp_err_o  out  1  transaction timed out.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  ADDR_W  address.
- wbm_dat_o  out  DATA_W  write data.
- wbm_sel_o  out  DATA_W/8  byte selects.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  DATA_W  slave read data.

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - state IDLE.
  - All wbm_* outputs 0; rsp_valid_o, rsp_err_o, rsp_dat_o 0; timeout counter 0.
  - req_ready_o is 1 one cycle after reset deasserts, and is held 0 while reset is active.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i: register we/adr/dat/sel into wbm_* outputs, set wbm_cyc_o = wbm_stb_o = 1, clear the counter, go to BUS.
  - wbm_ack_i is ignored in IDLE.
- BUS:
  - req_ready_o = 0; cyc/stb/we/adr/dat/sel held stable.
  - Counter increments each cycle without ack.
  - On wbm_ack_i sampled high:
    - Drop cyc/stb on the same edge.
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write; rsp_err_o = 0.
    - Go to RESP.
  - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with no ack:
    - Drop cyc/stb; rsp_err_o = 1, rsp_dat_o = 0; go to RESP.
    - cyc/stb are therefore high for exactly TIMEOUT_CYCLES cycles.
  - Ack and timeout on the same edge: ack wins, err = 0.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o held stable until rsp_ready_i.
  - On rsp_ready_i: clear rsp_valid_o and go to IDLE; the next request is accepted one cycle later.
  - req_ready_o = 0.
- Latency:
  - Accept at edge N; cyc/stb high from N.
  - Ack sampled at edge N+k (k ≥ 1); rsp_valid_o high from N+k.
  - Minimum request-to-response is 1 cycle; back-to-back throughput is 1 transaction per k+2 cycles minimum.
- One outstanding transaction only. No pipelined mode, no bursts, no retry/err_i.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o hold their last values after a cycle ends; they are don't-care while cyc = 0.
- Reset mid-BUS drops cyc/stb immediately, with no response generated.

Test Plan:
- Write: req adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, we=1; slave acks on the 3rd cycle → cyc/stb/we high exactly 3 cycles with stable adr/dat → rsp_valid=1, err=0, rsp_dat=0x0.
- Read: adr=0x3000_0000, we=0; slave returns 0x1234_5678 with ack on the 1st cycle → cyc high 1 cycle → rsp_dat=0x1234_5678, err=0 on the next cycle.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → cyc/stb high exactly 8 cycles → rsp_err=1, rsp_dat=0; a later ack is ignored.
- Backpressure:
  - Hold rsp_ready_i low 5 cycles after response → rsp_valid/rsp_dat stable, req_ready=0, a new req_valid is not accepted.
  - Raise rsp_ready → next request is accepted the cycle after.
- Reset mid-BUS: assert wb_rst_ni low 2 cycles into a read → cyc/stb/rsp_valid go 0 without a clock edge → after release, a fresh read completes normally.
- Back-to-back: 4 requests, req_valid held high, ack k=1, rsp_ready tied 1 → 4 responses in order, one every 3 cycles, cyc never high across a boundary.
